// File: rtl/uart_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_rx_pkg
//  Purpose  : Shared types and constants for the host->board UART command
//             receiver: byte / frame state enums, frame header and length,
//             and the clocks-per-bit derivation.
//  Config   : UART_CMD_RX_PARITY_EN adds the RX_PARITY byte state (8E1).
//  Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_rx_pkg;

    // Byte-level receiver states
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_CMD_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    // Frame-level parser states: header hunt, then one state per frame byte
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        ADDR = 3'd1,
        D2   = 3'd2,
        D1   = 3'd3,
        D0   = 3'd4,
        CSUM = 3'd5
    } frame_state_t;

    localparam logic [7:0] CMD_HDR   = 8'hAA;
    localparam int         FRAME_LEN = 6;

    // Number of system clocks per serial bit
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Purpose  : Asynchronous serial byte receiver. 2-flop synchroniser, start
//             bit validation at mid-bit, 8 data samples LSB first, stop-bit
//             check. Optional even parity bit (UART_CMD_RX_PARITY_EN).
//  Ports    : clk, rst       - system clock, synchronous active-high reset
//             rx_uart        - serial input, idle high
//             byte_done      - one-cycle strobe, byte_data valid
//             byte_data[7:0] - last received byte
//             frame_err      - one-cycle strobe, bad stop (or parity) bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_uart,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int              c_CW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    rx_state_t       r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_done;
    logic            r_ferr;
`ifdef UART_CMD_RX_PARITY_EN
    logic            r_par_ok;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RX_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            r_par_ok  <= 1'b0;
`endif
        end else begin
            r_sync1 <= rx_uart;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;

            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!r_sync2) begin
                        r_state <= RX_START;
                    end
                end

                // Re-check the line at mid start bit; a short low pulse is
                // treated as noise and silently dropped.
                RX_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                RX_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

`ifdef UART_CMD_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero.
                RX_PARITY: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt    <= '0;
                        r_par_ok <= ~(^r_shift ^ r_sync2);
                        r_state  <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
`endif

                // Decide at mid stop bit and return to idle immediately so a
                // start edge in the second half of the stop bit is caught.
                RX_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
`ifdef UART_CMD_RX_PARITY_EN
                        if (r_sync2 && r_par_ok) begin
`else
                        if (r_sync2) begin
`endif
                            r_done <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_done = r_done;
    assign byte_data = r_shift;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_rx
//  Purpose  : Host->board UART command receiver. Parses 6-byte frames
//             [0xAA, ADDR, D23:16, D15:8, D7:0, CSUM] with
//             CSUM = ADDR ^ D2 ^ D1 ^ D0 and emits a 24-bit register write.
//  Params   : CLK_FREQ (Hz), BAUD, TIMEOUT_CYC (max idle cycles in a frame)
//  Ports    : clk, rst            - system clock, synchronous active-high reset
//             rx_uart             - serial input, idle high
//             cmd_valid           - one-cycle pulse, good frame received
//             cmd_addr[7:0]       - address of last good frame
//             cmd_data[23:0]      - data of last good frame
//             frame_err           - one-cycle pulse, bad stop/parity bit
//             csum_err            - one-cycle pulse, checksum mismatch
//             busy                - frame in progress (header seen)
//  Config   : UART_CMD_RX_PARITY_EN selects 8E1 line format (default 8N1).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_uart,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [23:0] cmd_data,
    output logic        frame_err,
    output logic        csum_err,
    output logic        busy
);

    localparam int              c_CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int              c_PW           = (FRAME_LEN - 2) * 8;
    localparam int              c_TW           = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TO_LAST      = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [c_TW-1:0] c_TO_ONE       = c_TW'(1);

    logic        w_byte_done;
    logic [7:0]  w_byte_data;
    logic        w_frame_err;

    frame_state_t    r_state;
    logic [c_PW-1:0] r_payload;
    logic [7:0]      r_csum;
    logic [c_TW-1:0] r_to_cnt;
    logic            r_cmd_valid;
    logic            r_csum_err;
    logic [7:0]      r_cmd_addr;
    logic [23:0]     r_cmd_data;

    uart_rx_byte #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst       (rst),
        .rx_uart   (rx_uart),
        .byte_done (w_byte_done),
        .byte_data (w_byte_data),
        .frame_err (w_frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_payload   <= '0;
            r_csum      <= '0;
            r_to_cnt    <= '0;
            r_cmd_valid <= 1'b0;
            r_csum_err  <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_csum_err  <= 1'b0;

            // Inter-byte idle counter, only meaningful inside a frame
            if (w_byte_done || (r_state == HUNT)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end

            if (w_frame_err) begin
                r_state <= HUNT;
            end else if (w_byte_done) begin
                case (r_state)
                    HUNT: begin
                        if (w_byte_data == CMD_HDR) begin
                            r_csum  <= '0;
                            r_state <= ADDR;
                        end
                    end
                    ADDR, D2, D1, D0: begin
                        // Payload bytes shift in MSB-first: ADDR ends on top
                        r_payload <= {r_payload[c_PW-9:0], w_byte_data};
                        r_csum    <= r_csum ^ w_byte_data;
                        case (r_state)
                            ADDR:    r_state <= D2;
                            D2:      r_state <= D1;
                            D1:      r_state <= D0;
                            default: r_state <= CSUM;
                        endcase
                    end
                    CSUM: begin
                        if (w_byte_data == r_csum) begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_addr  <= r_payload[c_PW-1 -: 8];
                            r_cmd_data  <= r_payload[23:0];
                        end else begin
                            r_csum_err  <= 1'b1;
                        end
                        r_state <= HUNT;
                    end
                    default: r_state <= HUNT;
                endcase
            end else if ((r_state != HUNT) && (r_to_cnt == c_TO_LAST)) begin
                r_state <= HUNT;
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_data  = r_cmd_data;
    assign csum_err  = r_csum_err;
    assign frame_err = w_frame_err;
    assign busy      = (r_state != HUNT);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_rx
//  Purpose  : Self-checking bench for uart_cmd_rx. Directed scenarios plus
//             random frames; a frame-level model fills an event queue that a
//             monitor drains whenever the DUT pulses an output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;

    localparam int CLK_FREQ    = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int CPB         = CLK_FREQ / BAUD;   // 16 clocks per bit
    localparam int TIMEOUT_CYC = 2000;

    localparam int K_VALID = 0;
    localparam int K_CSUM  = 1;
    localparam int K_FERR  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_uart = 1'b1;
    logic        cmd_valid;
    logic [7:0]  cmd_addr;
    logic [23:0] cmd_data;
    logic        frame_err;
    logic        csum_err;
    logic        busy;

    uart_cmd_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_uart   (rx_uart),
        .cmd_valid (cmd_valid),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .frame_err (frame_err),
        .csum_err  (csum_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [23:0] data;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Frame-level reference model state
    bit          m_in_frame = 1'b0;
    logic [7:0]  m_buf[$];
    logic [7:0]  m_addr = 8'h00;
    logic [23:0] m_data = 24'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        m_in_frame = 1'b0;
        m_buf.delete();
        m_addr = 8'h00;
        m_data = 24'h0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good_stop);
        logic [7:0] x;
        if (!good_stop) begin
            sb.push_back('{K_FERR, m_addr, m_data});
            m_in_frame = 1'b0;
            m_buf.delete();
            return;
        end
        if (!m_in_frame) begin
            if (b == 8'hAA) begin
                m_in_frame = 1'b1;
                m_buf.delete();
            end
            return;
        end
        m_buf.push_back(b);
        if (m_buf.size() == 5) begin
            x = m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3];
            if (x == m_buf[4]) begin
                m_addr = m_buf[0];
                m_data = {m_buf[1], m_buf[2], m_buf[3]};
                sb.push_back('{K_VALID, m_addr, m_data});
            end else begin
                sb.push_back('{K_CSUM, m_addr, m_data});
            end
            m_in_frame = 1'b0;
            m_buf.delete();
        end
    endtask

    // ------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        model_byte(b, good_stop);
        rx_uart = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_uart = b[i];
            tick(CPB);
        end
        if (good_stop) begin
            rx_uart = 1'b1;
            tick(CPB);
        end else begin
            // Low stop bit released early enough that its tail after the
            // mid-stop sample is shorter than a half bit (no false start).
            rx_uart = 1'b0;
            tick(CPB * 3 / 4);
            rx_uart = 1'b1;
            tick(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [23:0] d, input logic [7:0] cs);
        send_byte(8'hAA, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d[23:16], 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
        send_byte(cs, 1'b1);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] a, input logic [23:0] d);
        return a ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    // -------------------------------------------------------------- monitor
    ev_t        mon_e;
    int         mon_kind;
    logic [2:0] mon_bits;

    always @(negedge clk) begin
        if (!rst) begin
            mon_bits = {cmd_valid, csum_err, frame_err};
            if (mon_bits != 3'b000) begin
                mon_kind = cmd_valid ? K_VALID : (csum_err ? K_CSUM : K_FERR);
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got {valid,csum_err,frame_err}=%b, expected no event", mon_bits);
                end else begin
                    mon_e = sb.pop_front();
                    if ((mon_bits != 3'b100 && mon_bits != 3'b010 && mon_bits != 3'b001) ||
                        mon_kind != mon_e.kind || cmd_addr !== mon_e.addr || cmd_data !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL event: got flags=%b kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                                 mon_bits, mon_kind, cmd_addr, cmd_data, mon_e.kind, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------- watchdog
    initial begin
        repeat (150_000) @(posedge clk);
        $display("FAIL watchdog: simulation still running after 150000 cycles, expected completion");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- main
    logic [7:0]  r_a;
    logic [23:0] r_d;
    logic [7:0]  r_cs;

    initial begin
        rst = 1'b1;
        rx_uart = 1'b1;
        model_reset();
        tick(5);
        check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("reset_cmd_addr", {24'd0, cmd_addr}, 32'd0);
        check("reset_cmd_data", {8'd0, cmd_data}, 32'd0);
        check("reset_errs", {30'd0, frame_err, csum_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(CPB);

        // Good frame: XOR of 01,12,34,56 is 0x71
        send_frame(8'h01, 24'h123456, 8'h71);
        tick(4);
        check("good_addr", {24'd0, cmd_addr}, 32'h01);
        check("good_data", {8'd0, cmd_data}, 32'h123456);
        check("good_idle_busy", {31'd0, busy}, 32'd0);

        // Bad checksums: outputs must hold the previous frame
        send_frame(8'h01, 24'h123456, 8'h00);
        send_frame(8'h01, 24'h123456, 8'h75);
        tick(4);
        check("csum_hold_addr", {24'd0, cmd_addr}, 32'h01);
        check("csum_hold_data", {8'd0, cmd_data}, 32'h123456);

        // Bad stop bit mid-frame, then a good frame
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        send_byte(8'h12, 1'b0);
        tick(2);
        check("busy_after_ferr", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 24'hA5AA5A, xsum(8'h3C, 24'hA5AA5A));

        // Short low glitch on the idle line
        rx_uart = 1'b0;
        tick(CPB / 2 - 3);
        rx_uart = 1'b1;
        tick(CPB);
        send_frame(8'h7E, 24'h00FF00, xsum(8'h7E, 24'h00FF00));

        // Inter-byte timeout
        send_byte(8'hAA, 1'b1);
        send_byte(8'h02, 1'b1);
        check("busy_before_timeout", {31'd0, busy}, 32'd1);
        tick(TIMEOUT_CYC + 4 * CPB);
        check("busy_after_timeout", {31'd0, busy}, 32'd0);
        m_in_frame = 1'b0;
        m_buf.delete();
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_frame(8'h02, 24'hC0FFEE, xsum(8'h02, 24'hC0FFEE));

        // Reset in the middle of the D1 byte
        send_byte(8'hAA, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h12, 1'b1);
        rx_uart = 1'b0;
        tick(CPB);
        rx_uart = 1'b1;
        tick(CPB);
        rx_uart = 1'b0;
        tick(CPB);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        rx_uart = 1'b1;
        tick(1);
        check("rst_mid_addr", {24'd0, cmd_addr}, 32'd0);
        check("rst_mid_data", {8'd0, cmd_data}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_pending", sb.size(), 32'd0);
        model_reset();
        rst = 1'b0;
        tick(CPB);
        send_frame(8'h10, 24'h654321, xsum(8'h10, 24'h654321));

        // Random frames with junk bytes, corrupted checksums and bad stops
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                r_a = 8'($urandom_range(0, 255));
                if (r_a == 8'hAA) r_a = 8'h55;
                send_byte(r_a, 1'b1);
            end
            r_a = 8'($urandom());
            r_d = 24'($urandom());
            if ($urandom_range(0, 3) == 0) r_d[15:8] = 8'hAA;
            r_cs = xsum(r_a, r_d);
            if ($urandom_range(0, 3) == 0) r_cs = r_cs ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 5) == 0) begin
                send_byte(8'hAA, 1'b1);
                send_byte(r_a, 1'b1);
                send_byte(r_d[23:16], 1'b0);
            end
            send_frame(r_a, r_d, r_cs);
            tick($urandom_range(0, CPB));
        end

        tick(4 * CPB);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
